// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU control path: opcodes, controller
// states, datapath select encodings and instruction field positions.
package cpu_pkg;

    // Opcodes carried in IR[7:6]
    localparam logic [1:0] OP_LI   = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_SW   = 2'b11;

    // Controller states; ST_WAIT is only reachable in the single-step build
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_WAIT   = 3'd6
    } state_e;

    // Writeback source select
    localparam logic WB_SEL_IMM = 1'b0;
    localparam logic WB_SEL_ALU = 1'b1;

    // ALU operand B select
    localparam logic ALU_B_RD2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    // Instruction field bit positions
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS1_HI = 3;
    localparam int RS1_LO = 2;
    localparam int RS2_HI = 1;
    localparam int RS2_LO = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: maps the latched instruction word to
// register addresses, datapath selects and write-type flags. The controller
// decides when these are presented and when the enables fire.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output logic [1:0] rf_ra1,
    output logic [1:0] rf_ra2,
    output logic [1:0] rf_wa,
    output logic       wb_sel,
    output logic       alu_b_sel,
    output logic       is_store,
    output logic       is_regwrite
);

    // Field extraction and per-opcode control decode
    always_comb begin
        rf_ra1      = 2'd0;
        rf_ra2      = 2'd0;
        rf_wa       = 2'd0;
        wb_sel      = WB_SEL_IMM;
        alu_b_sel   = ALU_B_RD2;
        is_store    = 1'b0;
        is_regwrite = 1'b0;
        case (ir[OPC_HI:OPC_LO])
            OP_LI: begin
                rf_wa       = ir[RD_HI:RD_LO];
                wb_sel      = WB_SEL_IMM;
                is_regwrite = 1'b1;
            end
            OP_ADD: begin
                rf_ra1      = ir[RS1_HI:RS1_LO];
                rf_ra2      = ir[RS2_HI:RS2_LO];
                alu_b_sel   = ALU_B_RD2;
                wb_sel      = WB_SEL_ALU;
                rf_wa       = ir[RD_HI:RD_LO];
                is_regwrite = 1'b1;
            end
            OP_ADDI: begin
                rf_ra1      = ir[RD_HI:RD_LO];
                alu_b_sel   = ALU_B_IMM;
                wb_sel      = WB_SEL_ALU;
                rf_wa       = ir[RD_HI:RD_LO];
                is_regwrite = 1'b1;
            end
            default: begin
                // OP_SW: rd supplies the store data through read port 1
                rf_ra1   = ir[RD_HI:RD_LO];
                is_store = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer for the 8-bit mini CPU. Owns the PC and IR,
// walks each instruction through FETCH/DECODE/EXEC/WB and drives the
// register-file, ALU-select and data-memory control lines.
// Optional feature macro CPU_CTRL_STEP_EN adds step_mode/step inputs and a
// WAIT state ahead of every FETCH for single-instruction stepping.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int PROG_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [1:0] rf_ra1,
    output logic [1:0] rf_ra2,
    output logic [1:0] rf_wa,
    output logic       rf_we,
    output logic       wb_sel,
    output logic       alu_b_sel,
    output logic [3:0] dmem_addr,
    output logic       dmem_we,
    output logic       busy,
    output logic       done,
    output logic [7:0] retired
`ifdef CPU_CTRL_STEP_EN
    ,
    input  logic       step_mode,
    input  logic       step
`endif
);

    localparam logic [3:0] LAST_PC = 4'(PROG_LEN - 1);

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] retired_q, retired_d;
    logic       done_q, done_d;
    state_e     fetch_entry;

    logic [1:0] dec_ra1, dec_ra2, dec_wa;
    logic       dec_wb_sel, dec_alu_b_sel, dec_is_store, dec_is_regwrite;
    logic       active;

`ifdef CPU_CTRL_STEP_EN
    logic step_prev_q, step_prev_d;
    logic step_rise;

    // Step edge detection so a held step runs only one instruction
    always_comb begin
        step_prev_d = step;
        step_rise   = step & ~step_prev_q;
        fetch_entry = step_mode ? ST_WAIT : ST_FETCH;
    end

    // Previous-step register for the edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= step_prev_d;
        end
    end
`else
    // Without stepping, every instruction goes straight to FETCH
    always_comb begin
        fetch_entry = ST_FETCH;
    end
`endif

    cpu_decode u_decode (
        .ir          (ir_q),
        .rf_ra1      (dec_ra1),
        .rf_ra2      (dec_ra2),
        .rf_wa       (dec_wa),
        .wb_sel      (dec_wb_sel),
        .alu_b_sel   (dec_alu_b_sel),
        .is_store    (dec_is_store),
        .is_regwrite (dec_is_regwrite)
    );

    // State, PC, IR, retire counter and done flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= 4'd0;
            ir_q      <= 8'd0;
            retired_q <= 8'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE and HALT
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = 4'd0;
                    state_d = fetch_entry;
                end
            end
`ifdef CPU_CTRL_STEP_EN
            ST_WAIT: begin
                if (step_rise) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FETCH: begin
                ir_d    = imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB: begin
                if (retired_q != 8'hFF) begin
                    retired_d = retired_q + 8'd1;
                end
                // The last instruction halts rather than advancing, so PC never wraps
                if (pc_q == LAST_PC) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                end else begin
                    pc_d    = pc_q + 4'd1;
                    state_d = fetch_entry;
                end
            end
            ST_HALT: begin
                if (start) begin
                    pc_d      = 4'd0;
                    retired_d = 8'd0;
                    state_d   = fetch_entry;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: addresses/selects held through DECODE..WB, enables only in WB
    always_comb begin
        active = (state_q == ST_DECODE) || (state_q == ST_EXEC) || (state_q == ST_WB);
        imem_addr = pc_q;
        rf_ra1    = active ? dec_ra1 : 2'd0;
        rf_ra2    = active ? dec_ra2 : 2'd0;
        rf_wa     = active ? dec_wa : 2'd0;
        wb_sel    = active ? dec_wb_sel : WB_SEL_IMM;
        alu_b_sel = active ? dec_alu_b_sel : ALU_B_RD2;
        dmem_addr = (active && dec_is_store) ? ir_q[IMM_HI:IMM_LO] : 4'd0;
        // Reset at the WB edge must suppress the write, so gate it here too
        rf_we     = (state_q == ST_WB) && dec_is_regwrite && !reset;
        dmem_we   = (state_q == ST_WB) && dec_is_store && !reset;
        busy      = (state_q == ST_FETCH) || active;
        done      = done_q;
        retired   = retired_q;
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: three instances with PROG_LEN 1, 4 and 16,
// each with its own program ROM; the PROG_LEN=4 instance drives a small
// register-file/ALU/data-memory model so writebacks can be checked by value.
module tb_cpu_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s1 = 1'b0, s4 = 1'b0, s16 = 1'b0;
    logic step_mode = 1'b0, step = 1'b0;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] prog1 [16];
    logic [7:0] prog4 [16];
    logic [7:0] prog16[16];

    // Instance outputs
    logic [3:0] ia1, ia4, ia16, da1, da4, da16;
    logic [1:0] ra1_1, ra2_1, wa1, ra1_4, ra2_4, wa4, ra1_16, ra2_16, wa16;
    logic       we1, we4, we16, wbs1, wbs4, wbs16, bs1, bs4, bs16;
    logic       dwe1, dwe4, dwe16, bz1, bz4, bz16, dn1, dn4, dn16;
    logic [7:0] rt1, rt4, rt16;

    cpu_ctrl #(.PROG_LEN(1)) u1 (
        .clk(clk), .reset(reset), .start(s1), .imem_addr(ia1), .imem_data(prog1[ia1]),
        .rf_ra1(ra1_1), .rf_ra2(ra2_1), .rf_wa(wa1), .rf_we(we1), .wb_sel(wbs1),
        .alu_b_sel(bs1), .dmem_addr(da1), .dmem_we(dwe1), .busy(bz1), .done(dn1),
        .retired(rt1)
`ifdef CPU_CTRL_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    cpu_ctrl #(.PROG_LEN(4)) u4 (
        .clk(clk), .reset(reset), .start(s4), .imem_addr(ia4), .imem_data(prog4[ia4]),
        .rf_ra1(ra1_4), .rf_ra2(ra2_4), .rf_wa(wa4), .rf_we(we4), .wb_sel(wbs4),
        .alu_b_sel(bs4), .dmem_addr(da4), .dmem_we(dwe4), .busy(bz4), .done(dn4),
        .retired(rt4)
`ifdef CPU_CTRL_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    cpu_ctrl #(.PROG_LEN(16)) u16 (
        .clk(clk), .reset(reset), .start(s16), .imem_addr(ia16), .imem_data(prog16[ia16]),
        .rf_ra1(ra1_16), .rf_ra2(ra2_16), .rf_wa(wa16), .rf_we(we16), .wb_sel(wbs16),
        .alu_b_sel(bs16), .dmem_addr(da16), .dmem_we(dwe16), .busy(bz16), .done(dn16),
        .retired(rt16)
`ifdef CPU_CTRL_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    // Datapath model behind u4
    logic [7:0] regs [4];
    logic [7:0] dmem [16];
    int         st_cnt4 = 0;
    logic [3:0] imm4;
    logic [7:0] alu4;

    always_comb begin
        imm4 = prog4[ia4][3:0];
        alu4 = regs[ra1_4] + (bs4 ? {4'd0, imm4} : regs[ra2_4]);
    end

    always @(posedge clk) begin
        if (we4) regs[wa4] <= wbs4 ? alu4 : {4'd0, imm4};
        if (dwe4) begin
            dmem[da4] <= regs[ra1_4];
            st_cnt4   <= st_cnt4 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cyc;
    int busy_cnt;
    int st_before;
    logic       saw_sw;
    logic [3:0] sw_addr;
    logic [1:0] sw_ra1;

    initial begin
        for (int i = 0; i < 16; i++) begin
            prog1[i]  = 8'h00;
            prog4[i]  = 8'h00;
            prog16[i] = 8'h00;
            dmem[i]   = 8'h00;
        end
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
        prog1[0]  = 8'h15;
        prog4[0]  = 8'h13;
        prog4[1]  = 8'h24;
        prog4[2]  = 8'h76;
        prog4[3]  = 8'hF9;
        prog16[0] = 8'hAF;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'd0, bz4}, 32'd0);
        check("rst_done", {31'd0, dn4}, 32'd0);
        check("rst_pc", {28'd0, ia16}, 32'd0);
        check("rst_retired", {24'd0, rt1}, 32'd0);
        reset = 1'b0;
        tick();

        // Single LI r1,5 with PROG_LEN=1
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        check("li_fetch_busy", {31'd0, bz1}, 32'd1);
        check("li_fetch_wa", {30'd0, wa1}, 32'd0);
        tick();
        check("li_decode_wa", {30'd0, wa1}, 32'd1);
        tick();
        tick();
        check("li_wb_we", {31'd0, we1}, 32'd1);
        check("li_wb_wa", {30'd0, wa1}, 32'd1);
        check("li_wb_sel", {31'd0, wbs1}, 32'd0);
        check("li_wb_done", {31'd0, dn1}, 32'd0);
        tick();
        check("li_done", {31'd0, dn1}, 32'd1);
        check("li_halt_busy", {31'd0, bz1}, 32'd0);
        check("li_retired", {24'd0, rt1}, 32'd1);
        tick();
        check("li_done_pulse", {31'd0, dn1}, 32'd0);
        check("li_halt_we", {31'd0, we1}, 32'd0);

        // Four-instruction program with store
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        saw_sw = 1'b0;
        sw_addr = 4'd0;
        sw_ra1 = 2'd0;
        while (!dn4 && cyc < 40) begin
            if (bz4) busy_cnt++;
            if (dwe4) begin
                saw_sw  = 1'b1;
                sw_addr = da4;
                sw_ra1  = ra1_4;
            end
            tick();
            cyc++;
        end
        check("prog4_done", {31'd0, dn4}, 32'd1);
        check("prog4_done_cycle", cyc, 32'd17);
        check("prog4_busy_cycles", busy_cnt, 32'd16);
        check("prog4_r3", {24'd0, regs[3]}, 32'd7);
        check("prog4_sw_seen", {31'd0, saw_sw}, 32'd1);
        check("prog4_sw_addr", {28'd0, sw_addr}, 32'd9);
        check("prog4_sw_ra1", {30'd0, sw_ra1}, 32'd3);
        check("prog4_mem9", {24'd0, dmem[9]}, 32'd7);
        check("prog4_retired", {24'd0, rt4}, 32'd4);

        // PROG_LEN=16 run: ADDI decode, ignored mid-run start, halt at PC 15
        s16 = 1'b1;
        tick();
        s16 = 1'b0;
        tick();
        check("addi_ra1", {30'd0, ra1_16}, 32'd2);
        check("addi_bsel", {31'd0, bs16}, 32'd1);
        check("addi_wa", {30'd0, wa16}, 32'd2);
        check("addi_wbsel", {31'd0, wbs16}, 32'd1);
        tick();
        tick();
        check("addi_we", {31'd0, we16}, 32'd1);
        cyc = 4;
        while (cyc < 20) begin
            tick();
            cyc++;
        end
        s16 = 1'b1;
        tick();
        s16 = 1'b0;
        cyc++;
        check("midrun_start_pc", {28'd0, ia16}, 32'd5);
        check("midrun_start_busy", {31'd0, bz16}, 32'd1);
        while (!dn16 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("p16_done", {31'd0, dn16}, 32'd1);
        check("p16_done_cycle", cyc, 32'd65);
        check("p16_retired", {24'd0, rt16}, 32'd16);
        check("p16_pc_nowrap", {28'd0, ia16}, 32'd15);
        tick();
        check("p16_halt_stay", {31'd0, bz16}, 32'd0);
        s16 = 1'b1;
        tick();
        s16 = 1'b0;
        check("restart_pc", {28'd0, ia16}, 32'd0);
        check("restart_retired", {24'd0, rt16}, 32'd0);
        check("restart_busy", {31'd0, bz16}, 32'd1);

        // Reset during the WB of the SW on u4
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("sw_wb_we_pre", {31'd0, dwe4}, 32'd1);
        check("sw_wb_addr_pre", {28'd0, da4}, 32'd9);
        st_before = st_cnt4;
        reset = 1'b1;
        #1;
        check("sw_wb_we_rst", {31'd0, dwe4}, 32'd0);
        tick();
        check("rst_store_cnt", st_cnt4, st_before);
        check("rst_mid_busy", {31'd0, bz4}, 32'd0);
        check("rst_mid_pc", {28'd0, ia4}, 32'd0);
        check("rst_mid_ra1", {30'd0, ra1_4}, 32'd0);
        check("rst_mid_daddr", {28'd0, da4}, 32'd0);
        check("rst_mid_retired", {24'd0, rt4}, 32'd0);
        check("rst_mid_done", {31'd0, dn4}, 32'd0);
        reset = 1'b0;
        tick();

`ifdef CPU_CTRL_STEP_EN
        // Single-step: a held step runs one instruction, a new pulse runs the next
        step_mode = 1'b1;
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        tick();
        tick();
        check("step_wait_busy", {31'd0, bz4}, 32'd0);
        check("step_wait_retired", {24'd0, rt4}, 32'd0);
        step = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        step = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("step_hold_retired", {24'd0, rt4}, 32'd1);
        check("step_hold_pc", {28'd0, ia4}, 32'd1);
        check("step_hold_busy", {31'd0, bz4}, 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("step_second_retired", {24'd0, rt4}, 32'd2);
        step_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
